ds_inst_queue: RTL

//   Parametrised instruction queue between fetch and decode. Holds up to DEPTH fetched
//   {fs_to_ds payload, instruction word} pairs with valid/ready handshakes on both sides.

---
 rtl/ds_inst_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/ds_inst_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry circular buffer of {payload, inst} pairs.
// Optional define DSIQ_BYPASS_EN adds a zero-latency empty-queue bypass.
module ds_inst_queue #(
  parameter int BUS_WD    = 65,
  parameter int INST_WD   = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     br_kill,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BUS_WD-1:0]        in_bus,
  input  logic [INST_WD-1:0]       in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BUS_WD-1:0]        out_bus,
  output logic [INST_WD-1:0]       out_inst,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     afull
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BUS_WD-1:0]  bus_mem  [DEPTH];
  logic [INST_WD-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic               kill, full, empty;
  logic               enq, deq, bypass, wr_en, rd_en;
  logic [BUS_WD-1:0]  head_bus;
  logic [INST_WD-1:0] head_inst;

  always_comb begin
    kill     = flush | br_kill;
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    in_ready = !full;
    enq      = in_valid & in_ready & !kill;
`ifdef DSIQ_BYPASS_EN
    // An empty queue presents the incoming entry directly; it is only stored if decode stalls.
    out_valid = (!empty | in_valid) & !kill;
    head_bus  = empty ? in_bus  : bus_mem[rd_ptr_q];
    head_inst = empty ? in_inst : inst_mem[rd_ptr_q];
    bypass    = empty & enq & out_ready;
`else
    out_valid = !empty & !kill;
    head_bus  = bus_mem[rd_ptr_q];
    head_inst = inst_mem[rd_ptr_q];
    bypass    = 1'b0;
`endif
    deq   = out_valid & out_ready;
    wr_en = enq & !bypass;
    rd_en = deq & !empty;

    out_bus  = out_valid ? head_bus  : '0;
    out_inst = out_valid ? head_inst : '0;
    count    = count_q;
    afull    = (count_q >= CNT_W'(AFULL_LVL));

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (kill) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bus_mem[wr_ptr_q]  <= in_bus;
      inst_mem[wr_ptr_q] <= in_inst;
    end
  end

endmodule
